// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: RISC-V load/store funct3 values and FSM states.
// The single-cycle CPU decoder imports the funct3 constants from here as well.
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Stores only have signed-width encodings; the unsigned variants are load-only.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
// Purely combinational; the alignment check only covers halfword and word sizes.
module lsu_lane_fmt
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        mem_wdata  = 32'd0;
        load_data  = 32'd0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                mem_wdata = {4{wdata[7:0]}};
                load_data = funct3[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            2'b01: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                mem_wdata  = {2{wdata[15:0]}};
                load_data  = funct3[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            2'b10: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                mem_wdata  = wdata;
                load_data  = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and load/store sequencer for the single-port byte-lane data memory.
// One transaction at a time: IDLE -> CHECK -> ACCESS -> RESP, or CHECK -> RESP on a decode error.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*32-1:0]     req_wdata,
    input  logic [NREQ*3-1:0]      req_funct3,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_wen,
    output logic                   mem_ren,
    output logic [3:0]             mem_be,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [31:0]       wdata_arr [NREQ];
    logic [2:0]        f3_arr    [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_port
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
            assign f3_arr[gi]    = req_funct3[gi*3 +: 3];
        end
    endgenerate

    state_t            state_reg;
    logic              ptr_reg;
    logic              owner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        f3_reg;
    logic              err_reg;
    logic [31:0]       rdata_reg;
    logic [NREQ-1:0]   rsp_valid_reg;
    logic              mem_wen_reg;
    logic              mem_ren_reg;
    logic [3:0]        mem_be_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    // Gating with rst_n keeps req_ready low while reset is held even though IDLE is the reset state.
    logic grant_any;
    logic winner;
    assign grant_any = rst_n && (state_reg == IDLE) && (|req_valid);
    assign winner    = req_valid[ptr_reg] ? ptr_reg : ~ptr_reg;

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[winner] = 1'b1;
        end
    end

    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_load;
    logic        fmt_misaligned;
    logic        dec_err;

    lsu_lane_fmt u_lane_fmt (
        .funct3     (f3_reg),
        .addr_lo    (addr_reg[1:0]),
        .wdata      (wdata_reg),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .mem_wdata  (fmt_wdata),
        .load_data  (fmt_load),
        .misaligned (fmt_misaligned)
    );

    assign dec_err = fmt_misaligned | f3_illegal(we_reg, f3_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= 1'b0;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            f3_reg        <= 3'd0;
            err_reg       <= 1'b0;
            rdata_reg     <= 32'd0;
            rsp_valid_reg <= '0;
            mem_wen_reg   <= 1'b0;
            mem_ren_reg   <= 1'b0;
            mem_be_reg    <= 4'd0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg <= winner;
                        we_reg    <= req_we[winner];
                        addr_reg  <= addr_arr[winner];
                        wdata_reg <= wdata_arr[winner];
                        f3_reg    <= f3_arr[winner];
                        ptr_reg   <= ~winner;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (dec_err) begin
                        err_reg                  <= 1'b1;
                        rdata_reg                <= 32'd0;
                        rsp_valid_reg            <= '0;
                        rsp_valid_reg[owner_reg] <= 1'b1;
                        state_reg                <= RESP;
                    end else begin
                        mem_wen_reg   <= we_reg;
                        mem_ren_reg   <= ~we_reg;
                        mem_be_reg    <= we_reg ? fmt_be : 4'd0;
                        mem_addr_reg  <= {addr_reg[ADDR_W-1:2], 2'b00};
                        mem_wdata_reg <= we_reg ? fmt_wdata : 32'd0;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory read data is combinational, so the load lane is valid at this edge.
                    mem_wen_reg              <= 1'b0;
                    mem_ren_reg              <= 1'b0;
                    mem_be_reg               <= 4'd0;
                    mem_addr_reg             <= '0;
                    mem_wdata_reg            <= 32'd0;
                    err_reg                  <= 1'b0;
                    rdata_reg                <= we_reg ? 32'd0 : fmt_load;
                    rsp_valid_reg            <= '0;
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    state_reg                <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        err_reg       <= 1'b0;
                        rdata_reg     <= 32'd0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;
    assign mem_wen   = mem_wen_reg;
    assign mem_ren   = mem_ren_reg;
    assign mem_be    = mem_be_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory on the falling edge, byte-level reference model,
// directed scenarios followed by randomized single-port transactions.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [5:0]  req_funct3;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wen;
    logic        mem_ren;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .NREQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Environment memory: 256 bytes, written on the falling edge like the real array.
    logic [7:0] env_mem [256];
    logic       fill_mem;

    always @(negedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= pat(i);
        end else if (mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) env_mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        mem_rdata = {env_mem[8'(mem_addr[7:0] + 8'd3)], env_mem[8'(mem_addr[7:0] + 8'd2)],
                     env_mem[8'(mem_addr[7:0] + 8'd1)], env_mem[mem_addr[7:0]]};
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    int         ref_ptr;
    int         pass_cnt;
    int         total_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int f3_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic ref_illegal(input logic we, input logic [2:0] f3);
        if (we) return !(f3 inside {3'd0, 3'd1, 3'd2});
        return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a[7:0]];
        b1 = ref_mem[8'(a[7:0] + 8'd1)];
        b2 = ref_mem[8'(a[7:0] + 8'd2)];
        b3 = ref_mem[8'(a[7:0] + 8'd3)];
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd4:    return {24'd0, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd5:    return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // One lone-port transaction; entered and left just after a falling edge with the DUT idle.
    task automatic run_txn(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3, input int stall,
                           output logic [31:0] got);
        logic [1:0]  oh;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          size;
        int          waits;
        oh      = 2'b01 << p;
        size    = f3_size(f3);
        exp_err = ref_illegal(we, f3) || ((addr % size) != 0);
        exp_rd  = (we || exp_err) ? 32'd0 : ref_load(addr, f3);
        exp_be  = 4'(((1 << size) - 1) << (addr % 4));
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];

        req_valid             = oh;
        req_we[p]             = we;
        req_addr[p*32 +: 32]  = addr;
        req_wdata[p*32 +: 32] = wd;
        req_funct3[p*3 +: 3]  = f3;
        #1;
        waits = 0;
        while (!req_ready[p] && waits < 20) begin
            @(negedge clk); #1;
            waits++;
        end
        chk("accept_wait", 32'(waits), 32'd0);
        chk("req_ready", 32'(req_ready), 32'(oh));
        ref_ptr = 1 - p;

        @(negedge clk);
        req_valid  = 2'b00;
        req_we     = 2'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        req_funct3 = 6'($urandom);
        #1;
        chk("check_mem_idle", 32'({mem_wen, mem_ren}), 32'd0);

        @(negedge clk); #1;
        if (exp_err) begin
            chk("err_no_mem", 32'({mem_wen, mem_ren}), 32'd0);
            chk("err_rsp_valid", 32'(rsp_valid), 32'(oh));
        end else begin
            chk("acc_ren", 32'(mem_ren), 32'(!we));
            chk("acc_wen", 32'(mem_wen), 32'(we));
            chk("acc_addr", mem_addr, addr & ~32'h3);
            if (we) begin
                chk("acc_be", 32'(mem_be), 32'(exp_be));
                chk("acc_wdata", mem_wdata, exp_wd);
                for (int i = 0; i < size; i++) ref_mem[8'(addr[7:0] + 8'(i))] = wd[8*i +: 8];
            end
            chk("acc_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk); #1;
            chk("rsp_latency", 32'(rsp_valid), 32'(oh));
            chk("rsp_mem_idle", 32'({mem_wen, mem_ren}), 32'd0);
        end

        // Back-pressure: the other port asks for service and the non-owner ready is toggled.
        for (int s = 0; s < stall; s++) begin
            req_valid[1-p]            = 1'b1;
            req_we[1-p]               = 1'b0;
            req_funct3[(1-p)*3 +: 3]  = 3'd2;
            rsp_ready                 = ~oh;
            @(negedge clk); #1;
            chk("stall_no_accept", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(rsp_valid), 32'(oh));
            chk("stall_rdata", rsp_rdata, exp_rd);
        end
        req_valid = 2'b00;
        rsp_ready = oh;
        #1;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        got = rsp_rdata;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    // Both ports request loads continuously; the grant order follows the reference pointer.
    task automatic grant_seq(input int n);
        int          waits;
        int          exp_w;
        logic [31:0] a;
        req_valid          = 2'b11;
        req_we             = 2'b00;
        req_addr[31:0]     = 32'h10;
        req_addr[63:32]    = 32'h20;
        req_funct3         = {3'd2, 3'd2};
        rsp_ready          = 2'b11;
        #1;
        for (int k = 0; k < n; k++) begin
            waits = 0;
            while (req_ready == 2'b00 && waits < 20) begin
                @(negedge clk); #1;
                waits++;
            end
            exp_w = ref_ptr;
            ref_ptr = 1 - exp_w;
            chk("grant_order", 32'(req_ready), 32'(2'b01 << exp_w));
            a = (exp_w == 0) ? 32'h10 : 32'h20;
            waits = 0;
            while (rsp_valid == 2'b00 && waits < 20) begin
                @(negedge clk); #1;
                waits++;
            end
            chk("grant_rsp_port", 32'(rsp_valid), 32'(2'b01 << exp_w));
            chk("grant_rdata", rsp_rdata, ref_load(a, 3'd2));
            @(negedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        logic [2:0]  f3;
        pass_cnt   = 0;
        total_cnt  = 0;
        ref_ptr    = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_we     = 2'b00;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_funct3 = 6'd0;
        rsp_ready  = 2'b00;
        fill_mem   = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        repeat (3) @(negedge clk);
        fill_mem  = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_ctl", 32'({mem_wen, mem_ren, mem_be}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Port 1 alone right after reset, then the word/byte/half sequence on port 0.
        run_txn(1, 1'b0, 32'h04, 32'd0, 3'd2, 0, got);
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, got);
        run_txn(0, 1'b0, 32'h10, 32'd0, 3'd2, 0, got);
        chk("lw_10", got, 32'hDEADBEEF);
        run_txn(0, 1'b0, 32'h13, 32'd0, 3'd0, 0, got);
        chk("lb_13", got, 32'hFFFFFFDE);
        run_txn(0, 1'b0, 32'h13, 32'd0, 3'd4, 0, got);
        chk("lbu_13", got, 32'h000000DE);
        run_txn(0, 1'b0, 32'h12, 32'd0, 3'd1, 0, got);
        chk("lh_12", got, 32'hFFFFDEAD);
        run_txn(0, 1'b0, 32'h10, 32'd0, 3'd5, 0, got);
        chk("lhu_10", got, 32'h0000BEEF);
        run_txn(0, 1'b1, 32'h11, 32'h55, 3'd0, 0, got);
        run_txn(0, 1'b0, 32'h10, 32'd0, 3'd2, 0, got);
        chk("lw_after_sb", got, 32'hDEAD55EF);

        // Misaligned accesses leave memory untouched.
        run_txn(0, 1'b0, 32'h12, 32'd0, 3'd2, 0, got);
        chk("lw_12_zero", got, 32'd0);
        run_txn(1, 1'b1, 32'h11, 32'h1234, 3'd1, 0, got);
        run_txn(0, 1'b0, 32'h10, 32'd0, 3'd2, 5, got);
        chk("lw_after_err", got, 32'hDEAD55EF);

        grant_seq(4);

        // Reset asserted inside ACCESS of a port-0 store.
        @(negedge clk);
        req_valid          = 2'b01;
        req_we[0]          = 1'b1;
        req_addr[31:0]     = 32'h30;
        req_wdata[31:0]    = 32'hA5A55A5A;
        req_funct3[2:0]    = 3'd2;
        #1;
        chk("rst_txn_accept", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("rst_txn_in_access", 32'(mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_mem_ctl", 32'({mem_wen, mem_ren, mem_be}), 32'd0);
        chk("async_mem_addr", mem_addr, 32'd0);
        chk("async_mem_wdata", mem_wdata, 32'd0);
        chk("async_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ref_ptr = 0;
        #1;
        grant_seq(2);
        run_txn(1, 1'b0, 32'h30, 32'd0, 3'd2, 0, got);
        chk("store_lost", got, {pat(32'h33), pat(32'h32), pat(32'h31), pat(32'h30)});

        // Randomized lone-port traffic against the byte-level model.
        for (int t = 0; t < 40; t++) begin
            f3   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(f3_size(f3) - 1);
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
                    f3, int'($urandom_range(0, 2)), got);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
